// File: rtl/vcve2_multdiv_issue.sv
// Issue/collect stage for the slow multiplier/divider: latches one request from
// ID, steers the unit, keeps its intermediate registers and returns the result
// to writeback. Flushed operations are run to completion and discarded.
module vcve2_multdiv_issue #(
  parameter bit ResultReg = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_operator_i,
  input  logic [1:0]       req_signed_mode_i,
  input  logic [31:0]      req_op_a_i,
  input  logic [31:0]      req_op_b_i,
  input  logic [4:0]       req_rd_i,
  input  logic             flush_i,
  output logic             mult_en_o,
  output logic             div_en_o,
  output logic             mult_sel_o,
  output logic             div_sel_o,
  output logic [1:0]       operator_o,
  output logic [1:0]       signed_mode_o,
  output logic [31:0]      op_a_o,
  output logic [31:0]      op_b_o,
  output logic [1:0][33:0] imd_val_q_o,
  input  logic [1:0][33:0] imd_val_d_i,
  input  logic [1:0]       imd_val_we_i,
  output logic             multdiv_ready_id_o,
  input  logic [31:0]      multdiv_result_i,
  input  logic             valid_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [4:0]       wb_rd_o,
  output logic [31:0]      wb_result_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      operator_q;
  logic [1:0]      signed_mode_q;
  logic [31:0]     op_a_q;
  logic [31:0]     op_b_q;
  logic [4:0]      rd_q;
  logic [31:0]     result_q;
  logic [1:0][33:0] imd_q;
  logic            accept;
  logic            capture;
  logic            unit_active;

  assign unit_active = (state_q == BUSY) || (state_q == DRAIN);

  // Next-state and handshake decode
  always_comb begin
    state_d            = state_q;
    req_ready_o        = 1'b0;
    multdiv_ready_id_o = 1'b0;
    wb_valid_o         = 1'b0;
    accept             = 1'b0;
    capture            = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i && !flush_i) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (ResultReg) begin
          // Unit is never held: the result is parked locally instead.
          multdiv_ready_id_o = 1'b1;
          if (valid_i) begin
            if (flush_i) begin
              state_d = IDLE;
            end else begin
              capture = 1'b1;
              state_d = RESP;
            end
          end else if (flush_i) begin
            state_d = DRAIN;
          end
        end else begin
          wb_valid_o         = valid_i & ~flush_i;
          multdiv_ready_id_o = wb_ready_i | flush_i;
          if (valid_i && (wb_ready_i || flush_i)) begin
            state_d = IDLE;
          end else if (flush_i) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        multdiv_ready_id_o = 1'b1;
        if (valid_i) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        wb_valid_o = ~flush_i;
        if (wb_ready_i || flush_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latches and registered result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      operator_q    <= '0;
      signed_mode_q <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      rd_q          <= '0;
      result_q      <= '0;
    end else begin
      if (accept) begin
        operator_q    <= req_operator_i;
        signed_mode_q <= req_signed_mode_i;
        op_a_q        <= req_op_a_i;
        op_b_q        <= req_op_b_i;
        rd_q          <= req_rd_i;
      end
      if (capture) begin
        result_q <= multdiv_result_i;
      end
    end
  end

  // Intermediate registers, writable only while the unit owns the operation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      imd_q <= '0;
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (imd_val_we_i[k] && unit_active) begin
          imd_q[k] <= imd_val_d_i[k];
        end
      end
    end
  end

  assign mult_en_o     = unit_active & ~operator_q[1];
  assign mult_sel_o    = mult_en_o;
  assign div_en_o      = unit_active & operator_q[1];
  assign div_sel_o     = div_en_o;
  assign operator_o    = operator_q;
  assign signed_mode_o = signed_mode_q;
  assign op_a_o        = op_a_q;
  assign op_b_o        = op_b_q;
  assign imd_val_q_o   = imd_q;
  assign wb_rd_o       = rd_q;
  assign wb_result_o   = ResultReg ? result_q : multdiv_result_i;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_vcve2_multdiv_issue.sv
// Bench for vcve2_multdiv_issue: one instance per ResultReg setting, each with
// its own behavioural multdiv unit, request stream and result scoreboard.
module tb_vcve2_multdiv_issue;

  localparam int NCYC   = 3000;
  localparam int RST_AT = 400;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          lat;
    int          hold;
    int          fa;
    bit          dir;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             rq_valid [2];
  logic             rq_ready [2];
  logic [1:0]       rq_op    [2];
  logic [1:0]       rq_sm    [2];
  logic [31:0]      rq_a     [2];
  logic [31:0]      rq_b     [2];
  logic [4:0]       rq_rd    [2];
  logic             fl       [2];
  logic             m_en     [2];
  logic             d_en     [2];
  logic             m_sel    [2];
  logic             d_sel    [2];
  logic [1:0]       o_op     [2];
  logic [1:0]       o_sm     [2];
  logic [31:0]      o_a      [2];
  logic [31:0]      o_b      [2];
  logic [1:0][33:0] imd_q    [2];
  logic [1:0][33:0] imd_d    [2];
  logic [1:0]       imd_we   [2];
  logic             rdy_id   [2];
  logic [31:0]      u_res    [2];
  logic             u_valid  [2];
  logic             wbv      [2];
  logic             wbr      [2];
  logic [4:0]       wbrd     [2];
  logic [31:0]      wbres    [2];
  logic             busy     [2];

  vcve2_multdiv_issue #(.ResultReg(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(rq_valid[0]), .req_ready_o(rq_ready[0]),
    .req_operator_i(rq_op[0]), .req_signed_mode_i(rq_sm[0]),
    .req_op_a_i(rq_a[0]), .req_op_b_i(rq_b[0]), .req_rd_i(rq_rd[0]),
    .flush_i(fl[0]),
    .mult_en_o(m_en[0]), .div_en_o(d_en[0]), .mult_sel_o(m_sel[0]), .div_sel_o(d_sel[0]),
    .operator_o(o_op[0]), .signed_mode_o(o_sm[0]), .op_a_o(o_a[0]), .op_b_o(o_b[0]),
    .imd_val_q_o(imd_q[0]), .imd_val_d_i(imd_d[0]), .imd_val_we_i(imd_we[0]),
    .multdiv_ready_id_o(rdy_id[0]), .multdiv_result_i(u_res[0]), .valid_i(u_valid[0]),
    .wb_valid_o(wbv[0]), .wb_ready_i(wbr[0]), .wb_rd_o(wbrd[0]), .wb_result_o(wbres[0]),
    .busy_o(busy[0])
  );

  vcve2_multdiv_issue #(.ResultReg(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(rq_valid[1]), .req_ready_o(rq_ready[1]),
    .req_operator_i(rq_op[1]), .req_signed_mode_i(rq_sm[1]),
    .req_op_a_i(rq_a[1]), .req_op_b_i(rq_b[1]), .req_rd_i(rq_rd[1]),
    .flush_i(fl[1]),
    .mult_en_o(m_en[1]), .div_en_o(d_en[1]), .mult_sel_o(m_sel[1]), .div_sel_o(d_sel[1]),
    .operator_o(o_op[1]), .signed_mode_o(o_sm[1]), .op_a_o(o_a[1]), .op_b_o(o_b[1]),
    .imd_val_q_o(imd_q[1]), .imd_val_d_i(imd_d[1]), .imd_val_we_i(imd_we[1]),
    .multdiv_ready_id_o(rdy_id[1]), .multdiv_result_i(u_res[1]), .valid_i(u_valid[1]),
    .wb_valid_o(wbv[1]), .wb_ready_i(wbr[1]), .wb_rd_o(wbrd[1]), .wb_result_o(wbres[1]),
    .busy_o(busy[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic ck(string nm, int k, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (ResultReg=%0d) t=%0t got=%h want=%h", nm, k, $time, act, exp);
    end
  endtask

  // RISC-V M-extension semantics
  function automatic logic [31:0] ref_md(logic [1:0] op, logic [1:0] sm,
                                         logic [31:0] a, logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = sm[0] ? {{32{a[31]}}, a} : {32'h0, a};
    xb = sm[1] ? {{32{b[31]}}, b} : {32'h0, b};
    p  = xa * xb;
    if (op == 2'd0) return p[31:0];
    if (op == 2'd1) return p[63:32];
    if (b == 32'h0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
    if (sm[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == 2'd2) ? a : 32'h0;
    if (sm[0]) return (op == 2'd2) ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
    return (op == 2'd2) ? a / b : a % b;
  endfunction

  function automatic vec_t mkv(logic [1:0] op, logic [1:0] sm, logic [31:0] a, logic [31:0] b,
                               logic [4:0] rd, int lat, int hold, int fa);
    vec_t v;
    v.op = op; v.sm = sm; v.a = a; v.b = b; v.rd = rd;
    v.lat = lat; v.hold = hold; v.fa = fa; v.dir = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    v.op   = 2'($urandom);
    v.sm   = v.op[1] ? {2{1'($urandom)}} : 2'($urandom);
    v.a    = pick();
    v.b    = pick();
    v.rd   = 5'($urandom);
    v.lat  = $urandom_range(1, 4);
    v.hold = 0;
    v.fa   = 0;
    v.dir  = 1'b0;
    return v;
  endfunction

  exp_t q0[$];
  exp_t q1[$];

  task automatic sb_push(int k, exp_t e);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic sb_drop(int k);
    if (k == 0) begin
      if (q0.size() > 0) void'(q0.pop_back());
    end else begin
      if (q1.size() > 0) void'(q1.pop_back());
    end
  endtask

  // Transaction-level model: 0 = idle, 1 = unit working (incl. killed), 2 = result parked
  int               ph     [2];
  bit               killed [2];
  int               cnt    [2];
  int               age    [2];
  int               hold   [2];
  int               fa     [2];
  bit               mdir   [2];
  logic [1:0]       mop    [2];
  logic [1:0][33:0] shadow [2];
  vec_t             cur    [2];
  bit               have_cur [2];
  int               dptr   [2];
  vec_t             dtab[$];

  initial begin
    bit exp_wbv;
    dtab.push_back(mkv(2'd2, 2'b11, 32'd100,        32'd0,          5'd5,  1, 0, 0));
    dtab.push_back(mkv(2'd3, 2'b11, 32'h8000_0000,  32'd0,          5'd6,  2, 0, 0));
    dtab.push_back(mkv(2'd2, 2'b11, 32'hFFFF_FFF9,  32'd2,          5'd7,  1, 0, 0));
    dtab.push_back(mkv(2'd3, 2'b11, 32'hFFFF_FFF9,  32'd2,          5'd8,  3, 0, 0));
    dtab.push_back(mkv(2'd1, 2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd9,  2, 5, 0));
    dtab.push_back(mkv(2'd0, 2'b00, 32'd3,          32'd4,          5'd10, 3, 0, 3));
    dtab.push_back(mkv(2'd2, 2'b00, 32'd9,          32'd3,          5'd11, 1, 0, 0));
    dtab.push_back(mkv(2'd0, 2'b00, 32'd6,          32'd7,          5'd12, 1, 0, 0));
    dtab.push_back(mkv(2'd0, 2'b00, 32'd6,          32'd7,          5'd13, 1, 0, 3));

    for (int k = 0; k < 2; k++) begin
      rq_valid[k] = 1'b0; rq_op[k] = '0; rq_sm[k] = '0; rq_a[k] = '0; rq_b[k] = '0;
      rq_rd[k] = '0; fl[k] = 1'b0; imd_d[k] = '0; imd_we[k] = '0; u_res[k] = '0;
      u_valid[k] = 1'b0; wbr[k] = 1'b0;
      ph[k] = 0; killed[k] = 1'b0; cnt[k] = 0; age[k] = 0; hold[k] = 0; fa[k] = 0;
      mdir[k] = 1'b0; mop[k] = '0; shadow[k] = '0; have_cur[k] = 1'b0; dptr[k] = 0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          ck("rst_req_ready", k, rq_ready[k], 1);
          ck("rst_wb_valid", k, wbv[k], 0);
          ck("rst_busy", k, busy[k], 0);
          ck("rst_ready_id", k, rdy_id[k], 0);
          ck("rst_mult_en", k, {m_en[k], m_sel[k], d_en[k], d_sel[k]}, 0);
          ck("rst_imd0", k, imd_q[k][0], 0);
          ck("rst_imd1", k, imd_q[k][1], 0);
          ck("rst_latched", k, {o_op[k], o_sm[k], o_a[k], o_b[k], wbrd[k]}, 0);
          ck("rst_result", k, wbres[k], 0);
          ph[k] = 0; killed[k] = 1'b0; cnt[k] = 0; hold[k] = 0; shadow[k] = '0;
          if (k == 0) q0.delete(); else q1.delete();
        end else begin
          exp_wbv = (k == 0) ? (ph[k] == 1 && !killed[k] && u_valid[k] && !fl[k])
                             : (ph[k] == 2 && !fl[k]);
          ck("req_ready", k, rq_ready[k], ph[k] == 0);
          ck("busy", k, busy[k], ph[k] != 0);
          ck("wb_valid", k, wbv[k], exp_wbv);
          ck("mult_en_sel", k, {m_en[k], m_sel[k]}, {2{ph[k] == 1 && !mop[k][1]}});
          ck("div_en_sel", k, {d_en[k], d_sel[k]}, {2{ph[k] == 1 && mop[k][1]}});
          ck("imd0", k, imd_q[k][0], shadow[k][0]);
          ck("imd1", k, imd_q[k][1], shadow[k][1]);
          if (ph[k] != 0) ck("operator", k, o_op[k], mop[k]);
          if (ph[k] == 1)
            ck("ready_id", k, rdy_id[k], (k == 1 || killed[k]) ? 1'b1 : (wbr[k] | fl[k]));

          // Effects of the coming clock edge
          case (ph[k])
            0: if (rq_valid[k] && !fl[k]) begin
              exp_t e;
              ph[k] = 1; killed[k] = 1'b0; age[k] = 1; cnt[k] = cur[k].lat;
              hold[k] = cur[k].hold; fa[k] = cur[k].fa; mdir[k] = cur[k].dir; mop[k] = cur[k].op;
              e.rd  = cur[k].rd;
              e.res = ref_md(cur[k].op, cur[k].sm, cur[k].a, cur[k].b);
              sb_push(k, e);
              have_cur[k] = 1'b0;
            end
            1: begin
              for (int j = 0; j < 2; j++)
                if (imd_we[k][j]) shadow[k][j] = imd_d[k][j];
              age[k]++;
              if (u_valid[k]) begin
                if (k == 0 && hold[k] > 0) hold[k]--;
                if (k == 1 || killed[k] || wbr[k] || fl[k]) begin
                  if (!killed[k] && fl[k]) sb_drop(k);
                  ph[k] = (k == 1 && !killed[k] && !fl[k]) ? 2 : 0;
                end
              end else begin
                if (cnt[k] > 0) cnt[k]--;
                if (fl[k] && !killed[k]) begin
                  killed[k] = 1'b1;
                  sb_drop(k);
                end
              end
            end
            default: begin
              age[k]++;
              if (hold[k] > 0) hold[k]--;
              if (fl[k]) begin
                ph[k] = 0;
                sb_drop(k);
              end else if (wbr[k]) begin
                ph[k] = 0;
              end
            end
          endcase
        end
      end

      @(posedge clk);
      #1;
      if (c == 1 || c == RST_AT + 2) rst_n = 1'b1;
      if (c == RST_AT) rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          rq_valid[k] = 1'b0; fl[k] = 1'b0; wbr[k] = 1'b0; u_valid[k] = 1'b0;
          u_res[k] = '0; imd_we[k] = '0; imd_d[k] = '0;
        end else begin
          bit stopping, dirnow;
          stopping = (c >= NCYC - 200);
          if (ph[k] == 0 && !have_cur[k]) begin
            if (dptr[k] < dtab.size()) begin
              cur[k] = dtab[dptr[k]];
              dptr[k]++;
            end else begin
              cur[k] = rnd_vec();
            end
            have_cur[k] = 1'b1;
          end
          dirnow = (ph[k] == 0) ? cur[k].dir : mdir[k];
          if (ph[k] == 0) begin
            rq_valid[k] = !stopping && (cur[k].dir || ($urandom % 3 != 0));
            rq_op[k] = cur[k].op; rq_sm[k] = cur[k].sm;
            rq_a[k] = cur[k].a; rq_b[k] = cur[k].b; rq_rd[k] = cur[k].rd;
          end else begin
            rq_valid[k] = !stopping && 1'($urandom);
            rq_op[k] = 2'($urandom); rq_sm[k] = 2'($urandom);
            rq_a[k] = $urandom; rq_b[k] = $urandom; rq_rd[k] = 5'($urandom);
          end
          fl[k]  = dirnow ? (ph[k] != 0 && fa[k] != 0 && age[k] == fa[k]) : ($urandom % 12 == 0);
          wbr[k] = (hold[k] > 0) ? 1'b0 : ($urandom % 3 != 0);
          u_valid[k] = (ph[k] == 1 && cnt[k] == 0);
          u_res[k] = u_valid[k] ? ref_md(o_op[k], o_sm[k], o_a[k], o_b[k]) : $urandom;
          imd_we[k] = 2'($urandom);
          imd_d[k]  = {2'($urandom), $urandom, 2'($urandom), $urandom};
        end
      end
    end

    for (int k = 0; k < 2; k++) begin
      ck("drain_idle", k, ph[k], 0);
      ck("drain_queue", k, (k == 0) ? q0.size() : q1.size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  exp_t mon_e;
  bit   mon_have;

  // Scoreboard monitor: every writeback transfer must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (wbv[k] && wbr[k]) begin
          mon_have = 1'b0;
          if (k == 0 && q0.size() > 0) begin
            mon_e = q0.pop_front();
            mon_have = 1'b1;
          end else if (k == 1 && q1.size() > 0) begin
            mon_e = q1.pop_front();
            mon_have = 1'b1;
          end
          ck("sb_entry_present", k, mon_have, 1);
          if (mon_have) begin
            ck("wb_rd", k, wbrd[k], mon_e.rd);
            ck("wb_result", k, wbres[k], mon_e.res);
          end
        end
      end
    end
  end

endmodule
